uart_line_rx: RTL
=================

Name: uart_line_rx

Overview:
- Serial receiver that consumes the computer's UART TxD line and buffers the received bytes.
- Deserialises 8N1 frames into a show-ahead byte FIFO and pulses a line-complete flag on LF (0x0A).
- Also keeps sticky framing-error and overrun flags.
- Sits downstream of the computer's serial output. Lets benches and FPGA top levels check monitor replies (prompt, echo of "m 0", "g 1") without reading waveforms.

Parameters:
- DIV_W, 16, width of the bit-period divisor input.
- FIFO_AW, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- div  input  DIV_W  clk cycles per bit; legal values 4..2^DIV_W-1; sampled at each start-bit detection.
- rxd  input  1  serial input, idle high, asynchronous to clk.
- rd  input  1  pop the FIFO head.
- dout  output  8  FIFO head byte (show-ahead).
- valid  output  1  FIFO non-empty.
- count  output  FIFO_AW+1  FIFO occupancy.
- line_done  output  1  one-cycle pulse when 0x0A is written into the FIFO.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte dropped because the FIFO was full.
- clr  input  1  synchronous clear of frame_err and overrun.

Behaviour:
- Reset (asserted low, async) forces:
  - all outputs 0, state IDLE, FIFO empty, pointers 0;
  - synchroniser flops to 1.
- Input synchronisation: rxd passes through a 2-flop synchroniser. All timing below is measured on the synchronised signal rxs.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: rxs==0 -> latch div into bit_len, load cnt=bit_len>>1, go START.
  - START: cnt counts down; at 0, if rxs==1 (glitch) -> IDLE with nothing pushed. Otherwise load cnt=bit_len, bit index 0, go DATA.
  - DATA: at cnt==0 sample rxs into shift[idx], LSB first, and reload cnt. After idx 7 -> STOP.
  - STOP: at cnt==0 sample rxs.
    - 1 -> push shift into FIFO.
    - 0 -> set frame_err, discard the byte.
    - Either way -> IDLE. The next start edge may be accepted in the following cycle.
- Push timing: FIFO write happens in the cycle after the stop sample. valid/count update in the same edge. line_done is asserted in that same cycle if the byte is 0x0A.
- FIFO:
  - dout always shows mem[rptr]; its value is don't-care when valid==0.
  - rd with valid==1 pops: rptr+1 mod depth, count-1.
  - rd with valid==0 is ignored.
  - Simultaneous push and pop: both succeed and count is unchanged. This holds even when full, i.e. a pop frees the slot.
  - Push when full without pop: byte dropped, overrun set, pointers unchanged, line_done not asserted.
  - Pointers wrap modulo 2^FIFO_AW; count ranges 0..2^FIFO_AW.
- Sticky flags:
  - clr clears frame_err and overrun.
  - If a set event coincides with clr, set wins.
- A mid-frame reset abandons the frame. After release the FSM waits in IDLE for the next falling edge; a line still low is treated as a start.
- div is latched only at start. Changes mid-frame take effect on the next frame.

Decomposition:
- Shared header (defs.v): FSM state encodings RX_IDLE/RX_START/RX_DATA/RX_STOP, LF constant 8'h0a, default DIV_W and FIFO_AW.
- One natural sub-module: byte_fifo (parameter FIFO_AW; ports clk, reset, wr, din, rd, dout, valid, full, count).
- Synchroniser and FSM stay in uart_line_rx.

Test Plan:
- Clean byte: div=8; drive 0x6D ('m') at 8 clk/bit -> valid=1, count=1, dout=0x6D, frame_err=0. Then rd 1 cycle -> valid=0, count=0.
- Line: send "m 0\n" (6D 20 30 0A) back-to-back with div=8 -> line_done pulses exactly once, together with the 4th push. Popping then yields 6D,20,30,0A in order.
- Glitch and frame error:
  - rxd low for 2 cycles (div=8) -> no push, FSM returns to IDLE.
  - Frame 0x55 with stop bit 0 -> frame_err=1 and count unchanged.
  - clr -> frame_err=0.
- Overrun: 17 bytes 0x00..0x10 with no rd -> count=16, overrun=1. Pops yield 0x00..0x0F; 0x10 is lost.
- Full plus pop: with FIFO full, assert rd in the push cycle of 0x41 -> count stays 16, overrun stays 0, and 0x41 is the last byte popped.
- Reset mid-frame: drop reset during data bit 3 of 0xA5 -> outputs 0 immediately. A subsequent full 0x3C frame is received correctly as 0x3C.

Source files
------------

// File: rtl/uart_line_rx_pkg.sv
// Shared definitions for the UART line receiver: FSM states, LF marker, default widths.
package uart_line_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] LF          = 8'h0a;
  localparam int         DIV_W_DEF   = 16;
  localparam int         FIFO_AW_DEF = 4;

endpackage

// File: rtl/uart_line_rx_byte_fifo.sv
// Show-ahead byte FIFO with occupancy count; a pop in the same cycle frees a slot for a push when full.
module uart_line_rx_byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [7:0]         din,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               valid,
  output logic               full,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = rd && valid;
  assign do_push = wr && (!full || do_pop);
  // Head is forced to zero while empty so every output reads 0 out of reset.
  assign dout    = valid ? mem_q[rptr_q] : 8'h00;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q alone, so
  // the array maps onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_line_rx.sv
// 8N1 UART receiver feeding a byte FIFO; flags LF arrival, framing errors and overruns.
module uart_line_rx
  import uart_line_rx_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   div,
  input  logic               rxd,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               valid,
  output logic [FIFO_AW:0]   count,
  output logic               line_done,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clr
);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] bit_len_q, bit_len_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             line_done_q, line_done_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rxs, fe_set, fifo_full, accept, drop, expired;

  assign rxs     = sync_q[1];
  // A count expires on the cycle it would step to zero, so one bit spans exactly bit_len clocks.
  assign expired = (cnt_q <= DIV_W'(1));
  assign accept  = push_q && (!fifo_full || (rd && valid));
  assign drop    = push_q && !accept;

  // NOTE: every signal assigned here gets its default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sync_d    = {sync_q[0], rxd};
    state_d   = state_q;
    bit_len_d = bit_len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      RX_IDLE: if (!rxs) begin
        bit_len_d = div;
        cnt_d     = div >> 1;
        state_d   = RX_START;
      end
      RX_START: begin
        if (!expired)  cnt_d = cnt_q - DIV_W'(1);
        else if (rxs)  state_d = RX_IDLE;
        else begin
          cnt_d   = bit_len_q;
          idx_d   = 3'd0;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!expired) cnt_d = cnt_q - DIV_W'(1);
        else begin
          shift_d[idx_q] = rxs;
          cnt_d          = bit_len_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!expired) cnt_d = cnt_q - DIV_W'(1);
        else begin
          push_d  = rxs;
          fe_set  = !rxs;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    line_done_d = accept && (shift_q == LF);
    frame_err_d = fe_set || (frame_err_q && !clr);
    overrun_d   = drop   || (overrun_q   && !clr);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b11;
      state_q     <= RX_IDLE;
      bit_len_q   <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      bit_len_q   <= bit_len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      line_done_q <= line_done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign line_done = line_done_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  uart_line_rx_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push_q),
    .din   (shift_q),
    .rd    (rd),
    .dout  (dout),
    .valid (valid),
    .full  (fifo_full),
    .count (count)
  );

endmodule
